// File: rtl/cci_mpf_if_pkg.sv
// ---------------------------------------------------------------------------
// cci_mpf_if_pkg
// Shared CCI-MPF types: C0/C1 TX request headers, cache-line data, RX
// response payloads, plus the stored entry of the AFU-side C1 TX buffer.
// No ports (package).
// ---------------------------------------------------------------------------
package cci_mpf_if_pkg;

  typedef logic [63:0] t_cci_clData;

  // Read request header
  typedef struct packed {
    logic [15:0] mdata;
    logic [31:0] addr;
  } t_cci_mpf_C0TxHdr;

  // Write / interrupt request header
  typedef struct packed {
    logic [15:0] mdata;
    logic [31:0] addr;
    logic        sop;
  } t_cci_mpf_C1TxHdr;

  typedef struct packed {
    logic        rspValid;
    logic [15:0] mdata;
    t_cci_clData data;
  } t_if_cci_c0_Rx;

  typedef struct packed {
    logic        rspValid;
    logic [15:0] mdata;
  } t_if_cci_c1_Rx;

  // One C1 buffer slot. A write and an interrupt presented in the same cycle
  // share a slot; the flags replay both valids to the parent.
  typedef struct packed {
    t_cci_mpf_C1TxHdr hdr;
    t_cci_clData      data;
    logic             wr;
    logic             ir;
  } t_cci_mpf_shim_buf_c1_entry;

endpackage

// File: rtl/cci_mpf_if.sv
// ---------------------------------------------------------------------------
// cci_mpf_if
// One CCI-MPF connection point between an AFU and the platform side.
// Modports:
//   to_afu : used by a shim facing the AFU  (TX requests in, almost-full,
//            RX responses and reset out)
//   to_qlp : used by a shim facing the platform (TX requests out, almost-full,
//            RX responses and reset in)
// ---------------------------------------------------------------------------
interface cci_mpf_if;
  import cci_mpf_if_pkg::*;

  t_cci_mpf_C0TxHdr C0TxHdr;
  logic             C0TxRdValid;
  logic             c0TxAlmFull;

  t_cci_mpf_C1TxHdr C1TxHdr;
  t_cci_clData      C1TxData;
  logic             C1TxWrValid;
  logic             C1TxIrValid;
  logic             c1TxAlmFull;

  t_if_cci_c0_Rx    c0Rx;
  t_if_cci_c1_Rx    c1Rx;
  logic             reset_n;

  modport to_afu (
    input  C0TxHdr, C0TxRdValid,
    input  C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
    output c0TxAlmFull, c1TxAlmFull,
    output c0Rx, c1Rx, reset_n
  );

  modport to_qlp (
    output C0TxHdr, C0TxRdValid,
    output C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
    input  c0TxAlmFull, c1TxAlmFull,
    input  c0Rx, c1Rx, reset_n
  );

endinterface

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// ---------------------------------------------------------------------------
// cci_mpf_prim_fifo_lutram
// Small distributed-RAM FIFO with a combinational head and a registered
// almost-full flag.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   enq_en/enq_data   push (accepted when not full, or when full with deq_en)
//   deq_en            pop the head (ignored while empty)
//   first             current head entry
//   notEmpty/notFull  occupancy flags from the current count
//   almostFull        registered (count_next >= THRESHOLD)
//   count_next        next-state occupancy, for external statistics
// ---------------------------------------------------------------------------
module cci_mpf_prim_fifo_lutram #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 8,
  parameter int THRESHOLD   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enq_en,
  input  logic [N_DATA_BITS-1:0]     enq_data,
  input  logic                       deq_en,
  output logic [N_DATA_BITS-1:0]     first,
  output logic                       notEmpty,
  output logic                       notFull,
  output logic                       almostFull,
  output logic [$clog2(N_ENTRIES):0] count_next
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(N_ENTRIES);
  localparam logic [CW-1:0] ALM_CNT  = CW'(THRESHOLD);

  logic [N_DATA_BITS-1:0] mem_q [N_ENTRIES];
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   alm_q;
  logic                   do_enq, do_deq;

  // A pop while full frees the slot the simultaneous push needs.
  assign do_deq = deq_en && (count_q != '0);
  assign do_enq = enq_en && ((count_q != FULL_CNT) || do_deq);

  // NOTE: every always_comb output gets a default first so no latch can be
  // inferred on a path that skips an assignment.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_deq) rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_enq) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + CW'(do_enq) - CW'(do_deq);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      alm_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      alm_q    <= (count_d >= ALM_CNT);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which slots hold live data, and a reset port would block LUTRAM mapping.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data;
  end

  assign first      = mem_q[rd_ptr_q];
  assign notEmpty   = (count_q != '0);
  assign notFull    = (count_q != FULL_CNT);
  assign almostFull = alm_q;
  assign count_next = count_d;

endmodule

// File: rtl/cci_mpf_shim_buffer_afu_tx.sv
// ---------------------------------------------------------------------------
// cci_mpf_shim_buffer_afu_tx
// AFU-side interposer: buffers C0 (read) and C1 (write/interrupt) TX
// requests in two independent FIFOs that the parent shim drains at its own
// pace, and raises almost-full toward the AFU early enough that no request
// is lost. RX responses and reset pass straight through toward the AFU.
// Ports:
//   clk, reset_n     clock, synchronous active-low reset
//   afu_raw          raw AFU connection (requests in, almost-full/RX out)
//   afu_buf          buffered view for the parent (FIFO heads as Tx signals)
//   c0TxDeqEn        parent consumes the C0 head this cycle
//   c1TxDeqEn        parent consumes the C1 head this cycle
//   overflowErr      sticky: a request arrived while its FIFO was full
//   c0HighWater/c1HighWater  max occupancy since reset; present only when
//                    CCI_MPF_SHIM_BUFFER_AFU_STATS_EN is defined
// ---------------------------------------------------------------------------
module cci_mpf_shim_buffer_afu_tx
  import cci_mpf_if_pkg::*;
#(
  parameter int N_ENTRIES     = 8,
  parameter int ALMFULL_SLACK = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  cci_mpf_if.to_afu     afu_raw,
  cci_mpf_if.to_qlp     afu_buf,
  input  logic          c0TxDeqEn,
  input  logic          c1TxDeqEn,
  output logic          overflowErr
`ifdef CCI_MPF_SHIM_BUFFER_AFU_STATS_EN
  ,
  output logic [$clog2(N_ENTRIES):0] c0HighWater,
  output logic [$clog2(N_ENTRIES):0] c1HighWater
`endif
);

  localparam int CW        = $clog2(N_ENTRIES) + 1;
  localparam int THRESHOLD = N_ENTRIES - ALMFULL_SLACK;

  t_cci_mpf_C0TxHdr           c0_head;
  t_cci_mpf_shim_buf_c1_entry c1_enq, c1_head;
  logic                       c0_not_empty, c0_not_full, c0_alm;
  logic                       c1_not_empty, c1_not_full, c1_alm;
  logic                       c1_push;
  logic [CW-1:0]              c0_cnt_next, c1_cnt_next;
  logic                       overflow_q, overflow_d;

  // ---- C0 ----
  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS ($bits(t_cci_mpf_C0TxHdr)),
    .N_ENTRIES   (N_ENTRIES),
    .THRESHOLD   (THRESHOLD)
  ) u_c0_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .enq_en     (afu_raw.C0TxRdValid),
    .enq_data   (afu_raw.C0TxHdr),
    .deq_en     (c0TxDeqEn),
    .first      (c0_head),
    .notEmpty   (c0_not_empty),
    .notFull    (c0_not_full),
    .almostFull (c0_alm),
    .count_next (c0_cnt_next)
  );

  // ---- C1: write and interrupt arriving together occupy a single slot ----
  assign c1_push = afu_raw.C1TxWrValid | afu_raw.C1TxIrValid;
  assign c1_enq  = '{hdr:  afu_raw.C1TxHdr,
                     data: afu_raw.C1TxData,
                     wr:   afu_raw.C1TxWrValid,
                     ir:   afu_raw.C1TxIrValid};

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS ($bits(t_cci_mpf_shim_buf_c1_entry)),
    .N_ENTRIES   (N_ENTRIES),
    .THRESHOLD   (THRESHOLD)
  ) u_c1_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .enq_en     (c1_push),
    .enq_data   (c1_enq),
    .deq_en     (c1TxDeqEn),
    .first      (c1_head),
    .notEmpty   (c1_not_empty),
    .notFull    (c1_not_full),
    .almostFull (c1_alm),
    .count_next (c1_cnt_next)
  );

  // ---- Buffered view for the parent ----
  assign afu_buf.C0TxHdr     = c0_head;
  assign afu_buf.C0TxRdValid = c0_not_empty;
  assign afu_buf.C1TxHdr     = c1_head.hdr;
  assign afu_buf.C1TxData    = c1_head.data;
  assign afu_buf.C1TxWrValid = c1_not_empty & c1_head.wr;
  assign afu_buf.C1TxIrValid = c1_not_empty & c1_head.ir;

  // ---- Toward the AFU: own almost-full; parent's almost-full is not used ----
  assign afu_raw.c0TxAlmFull = c0_alm;
  assign afu_raw.c1TxAlmFull = c1_alm;
  assign afu_raw.c0Rx        = afu_buf.c0Rx;
  assign afu_raw.c1Rx        = afu_buf.c1Rx;
  assign afu_raw.reset_n     = afu_buf.reset_n;

  // ---- Sticky overflow: a push is dropped only when full with no pop ----
  always_comb begin
    overflow_d = overflow_q;
    if (afu_raw.C0TxRdValid && !c0_not_full && !c0TxDeqEn) overflow_d = 1'b1;
    if (c1_push && !c1_not_full && !c1TxDeqEn)             overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign overflowErr = overflow_q;

`ifdef CCI_MPF_SHIM_BUFFER_AFU_STATS_EN
  // ---- High-water marks, tracked from next-state occupancy ----
  logic [CW-1:0] c0_hw_q, c0_hw_d;
  logic [CW-1:0] c1_hw_q, c1_hw_d;

  always_comb begin
    c0_hw_d = (c0_cnt_next > c0_hw_q) ? c0_cnt_next : c0_hw_q;
    c1_hw_d = (c1_cnt_next > c1_hw_q) ? c1_cnt_next : c1_hw_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c0_hw_q <= '0;
      c1_hw_q <= '0;
    end else begin
      c0_hw_q <= c0_hw_d;
      c1_hw_q <= c1_hw_d;
    end
  end

  assign c0HighWater = c0_hw_q;
  assign c1HighWater = c1_hw_q;
`else
  // Occupancy look-ahead is only consumed by the statistics counters.
  logic unused_cnt_next;
  assign unused_cnt_next = ^{c0_cnt_next, c1_cnt_next};
`endif

endmodule

// File: tb/tb_cci_mpf_shim_buffer_afu_tx.sv
// ---------------------------------------------------------------------------
// tb_cci_mpf_shim_buffer_afu_tx
// Self-checking bench: directed scenarios with literal expectations, then a
// randomized phase, all compared every cycle against a queue-based model.
// Honors CCI_MPF_SHIM_BUFFER_AFU_STATS_EN for the high-water outputs.
// ---------------------------------------------------------------------------
module tb_cci_mpf_shim_buffer_afu_tx;
  import cci_mpf_if_pkg::*;

  localparam int N     = 8;
  localparam int SLACK = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic deq0, deq1;
  logic ovf;

  cci_mpf_if raw_if ();
  cci_mpf_if buf_if ();

  assign buf_if.reset_n = rst_n;

`ifdef CCI_MPF_SHIM_BUFFER_AFU_STATS_EN
  logic [$clog2(N):0] c0_hw, c1_hw;
`endif

  cci_mpf_shim_buffer_afu_tx #(
    .N_ENTRIES     (N),
    .ALMFULL_SLACK (SLACK)
  ) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .afu_raw     (raw_if),
    .afu_buf     (buf_if),
    .c0TxDeqEn   (deq0),
    .c1TxDeqEn   (deq1),
    .overflowErr (ovf)
`ifdef CCI_MPF_SHIM_BUFFER_AFU_STATS_EN
    ,
    .c0HighWater (c0_hw),
    .c1HighWater (c1_hw)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- scoring ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_vec(name, 128'(act), 128'(exp));
  endtask

  // ---------------- reference model ----------------
  t_cci_mpf_C0TxHdr           m_c0q[$];
  t_cci_mpf_shim_buf_c1_entry m_c1q[$];
  bit m_alm0, m_alm1, m_ovf;
  int m_hw0, m_hw1;

  // Applies the inputs sampled at the current rising edge.
  task automatic model_update();
    int n0, n1;
    bit p0, p1;
    t_cci_mpf_shim_buf_c1_entry e;
    if (rst_n !== 1'b1) begin
      m_c0q.delete();
      m_c1q.delete();
      m_alm0 = 1'b0; m_alm1 = 1'b0; m_ovf = 1'b0;
      m_hw0 = 0; m_hw1 = 0;
    end else begin
      n0 = m_c0q.size();
      n1 = m_c1q.size();
      p0 = deq0 && (n0 > 0);
      p1 = deq1 && (n1 > 0);
      if (p0) void'(m_c0q.pop_front());
      if (p1) void'(m_c1q.pop_front());
      if (raw_if.C0TxRdValid) begin
        if (n0 == N && !p0) m_ovf = 1'b1;
        else m_c0q.push_back(raw_if.C0TxHdr);
      end
      if (raw_if.C1TxWrValid || raw_if.C1TxIrValid) begin
        e.hdr  = raw_if.C1TxHdr;
        e.data = raw_if.C1TxData;
        e.wr   = raw_if.C1TxWrValid;
        e.ir   = raw_if.C1TxIrValid;
        if (n1 == N && !p1) m_ovf = 1'b1;
        else m_c1q.push_back(e);
      end
      m_alm0 = (m_c0q.size() >= N - SLACK);
      m_alm1 = (m_c1q.size() >= N - SLACK);
      if (m_c0q.size() > m_hw0) m_hw0 = m_c0q.size();
      if (m_c1q.size() > m_hw1) m_hw1 = m_c1q.size();
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check_bit("c0_valid", buf_if.C0TxRdValid, m_c0q.size() != 0);
      if (m_c0q.size() != 0) check_vec("c0_head", 128'(buf_if.C0TxHdr), 128'(m_c0q[0]));
      check_bit("c1_wr_valid", buf_if.C1TxWrValid, (m_c1q.size() != 0) && m_c1q[0].wr);
      check_bit("c1_ir_valid", buf_if.C1TxIrValid, (m_c1q.size() != 0) && m_c1q[0].ir);
      if (m_c1q.size() != 0) begin
        check_vec("c1_hdr", 128'(buf_if.C1TxHdr), 128'(m_c1q[0].hdr));
        check_vec("c1_data", 128'(buf_if.C1TxData), 128'(m_c1q[0].data));
      end
      check_bit("c0_almfull", raw_if.c0TxAlmFull, m_alm0);
      check_bit("c1_almfull", raw_if.c1TxAlmFull, m_alm1);
      check_bit("overflow", ovf, m_ovf);
      check_vec("c0_rx_pass", 128'(raw_if.c0Rx), 128'(buf_if.c0Rx));
      check_vec("c1_rx_pass", 128'(raw_if.c1Rx), 128'(buf_if.c1Rx));
      check_bit("reset_pass", raw_if.reset_n, rst_n);
`ifdef CCI_MPF_SHIM_BUFFER_AFU_STATS_EN
      check_vec("c0_highwater", 128'(c0_hw), 128'(m_hw0));
      check_vec("c1_highwater", 128'(c1_hw), 128'(m_hw1));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    raw_if.C0TxRdValid = 1'b0;
    raw_if.C1TxWrValid = 1'b0;
    raw_if.C1TxIrValid = 1'b0;
    deq0 = 1'b0;
    deq1 = 1'b0;
  endtask

  function automatic t_cci_mpf_C0TxHdr mk_hdr0(input int i);
    t_cci_mpf_C0TxHdr h;
    h.mdata = 16'(i);
    h.addr  = 32'hA000_0000 + 32'(i);
    return h;
  endfunction

  function automatic t_cci_mpf_shim_buf_c1_entry mk_c1(input int i);
    t_cci_mpf_shim_buf_c1_entry e;
    e.hdr.mdata = 16'h0100 + 16'(i);
    e.hdr.addr  = 32'hB000_0000 + 32'(i);
    e.hdr.sop   = 1'(i);
    e.data      = {32'hD0D0_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
    e.wr        = 1'b1;
    e.ir        = (i % 3 == 0);
    return e;
  endfunction

  task automatic push_c0(input t_cci_mpf_C0TxHdr h);
    raw_if.C0TxRdValid = 1'b1;
    raw_if.C0TxHdr     = h;
  endtask

  task automatic push_c1(input t_cci_mpf_shim_buf_c1_entry e);
    raw_if.C1TxHdr     = e.hdr;
    raw_if.C1TxData    = e.data;
    raw_if.C1TxWrValid = e.wr;
    raw_if.C1TxIrValid = e.ir;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    t_cci_mpf_C0TxHdr           h;
    t_cci_mpf_shim_buf_c1_entry e;
    int push_pct, deq_pct, kind;

    idle();
    raw_if.C0TxHdr  = '0;
    raw_if.C1TxHdr  = '0;
    raw_if.C1TxData = '0;
    buf_if.c0Rx     = '0;
    buf_if.c1Rx     = '0;
    buf_if.c0TxAlmFull = 1'b0;
    buf_if.c1TxAlmFull = 1'b0;
    rst_n = 1'b0;

    // Reset state
    tick();
    cmp_en = 1'b1;
    tick();
    check_bit("rst_c0_valid", buf_if.C0TxRdValid, 1'b0);
    check_bit("rst_c1_wr_valid", buf_if.C1TxWrValid, 1'b0);
    check_bit("rst_c1_ir_valid", buf_if.C1TxIrValid, 1'b0);
    check_bit("rst_c0_almfull", raw_if.c0TxAlmFull, 1'b0);
    check_bit("rst_c1_almfull", raw_if.c1TxAlmFull, 1'b0);
    check_bit("rst_overflow", ovf, 1'b0);
    rst_n = 1'b1;

    // Three C0 pushes: head visible one cycle later, almost-full still low
    push_c0(mk_hdr0(0)); tick();
    check_bit("a_c0_valid_1st", buf_if.C0TxRdValid, 1'b1);
    check_vec("a_c0_head_1st", 128'(buf_if.C0TxHdr), 128'(mk_hdr0(0)));
    push_c0(mk_hdr0(1)); tick();
    push_c0(mk_hdr0(2)); tick();
    check_bit("a_alm_at3", raw_if.c0TxAlmFull, 1'b0);
    // Fourth push crosses the threshold
    push_c0(mk_hdr0(3)); tick();
    check_bit("a_alm_at4", raw_if.c0TxAlmFull, 1'b1);
    idle(); deq0 = 1'b1; tick();
    check_bit("a_alm_after_pop", raw_if.c0TxAlmFull, 1'b0);
    check_vec("a_head_after_pop", 128'(buf_if.C0TxHdr), 128'(mk_hdr0(1)));
    tick(); tick(); tick();
    idle();
    check_bit("a_c0_drained", buf_if.C0TxRdValid, 1'b0);

    // C1 full with simultaneous push and pop: no overflow, order preserved
    for (int i = 0; i < N; i++) begin
      push_c1(mk_c1(i)); tick();
    end
    check_bit("b_c1_alm_full", raw_if.c1TxAlmFull, 1'b1);
    push_c1(mk_c1(N)); deq1 = 1'b1; tick();
    check_bit("b_no_overflow", ovf, 1'b0);
    check_vec("b_head_after_swap", 128'(buf_if.C1TxData), 128'(mk_c1(1).data));
    idle(); deq1 = 1'b1;
    for (int i = 0; i < N; i++) tick();
    idle();
    check_bit("b_c1_drained", buf_if.C1TxWrValid, 1'b0);

    // C1 overflow: the ninth push is dropped and the error is sticky
    for (int i = 16; i < 16 + N; i++) begin
      push_c1(mk_c1(i)); tick();
    end
    push_c1(mk_c1(99)); tick();
    check_bit("c_overflow_set", ovf, 1'b1);
    idle(); deq1 = 1'b1; tick(); tick();
    check_bit("c_overflow_sticky", ovf, 1'b1);
    check_vec("c_head_after_2pops", 128'(buf_if.C1TxHdr), 128'(mk_c1(18).hdr));
    for (int i = 0; i < N - 2; i++) tick();
    idle();
    check_bit("c_dropped_not_stored", buf_if.C1TxWrValid, 1'b0);

    // Dequeue held on an empty C0 FIFO; push in cycle 3
    idle(); deq0 = 1'b1;
    tick(); tick();
    check_bit("d_empty_deq_valid", buf_if.C0TxRdValid, 1'b0);
    push_c0(mk_hdr0(30)); tick();
    check_bit("d_push_visible", buf_if.C0TxRdValid, 1'b1);
    check_vec("d_push_head", 128'(buf_if.C0TxHdr), 128'(mk_hdr0(30)));
    raw_if.C0TxRdValid = 1'b0; tick();
    check_bit("d_popped", buf_if.C0TxRdValid, 1'b0);
    tick();
    idle();

    // Reset mid-operation with five queued entries
    for (int i = 40; i < 45; i++) begin
      push_c0(mk_hdr0(i));
      if (i < 42) push_c1(mk_c1(i));
      else begin raw_if.C1TxWrValid = 1'b0; raw_if.C1TxIrValid = 1'b0; end
      tick();
    end
    idle();
    check_bit("e_alm_before_reset", raw_if.c0TxAlmFull, 1'b1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_bit("e_c0_valid", buf_if.C0TxRdValid, 1'b0);
    check_bit("e_c1_valid", buf_if.C1TxWrValid, 1'b0);
    check_bit("e_alm", raw_if.c0TxAlmFull, 1'b0);
    check_bit("e_overflow", ovf, 1'b0);
`ifdef CCI_MPF_SHIM_BUFFER_AFU_STATS_EN
    check_vec("e_c0_highwater", 128'(c0_hw), 128'd0);
    check_vec("e_c1_highwater", 128'(c1_hw), 128'd0);
`endif
    push_c0(mk_hdr0(50)); tick(); idle();
    check_vec("e_new_head", 128'(buf_if.C0TxHdr), 128'(mk_hdr0(50)));
    tick();

    // Randomized traffic in fill-heavy, drain-heavy and balanced phases
    for (int cyc = 0; cyc < 3000; cyc++) begin
      kind     = (cyc / 250) % 3;
      push_pct = (kind == 0) ? 75 : (kind == 1) ? 25 : 50;
      deq_pct  = (kind == 0) ? 25 : (kind == 1) ? 75 : 50;
      h.mdata = 16'($urandom());
      h.addr  = $urandom();
      raw_if.C0TxHdr     = h;
      raw_if.C0TxRdValid = (int'($urandom_range(0, 99)) < push_pct);
      e.hdr.mdata = 16'($urandom());
      e.hdr.addr  = $urandom();
      e.hdr.sop   = 1'($urandom());
      e.data      = {$urandom(), $urandom()};
      e.wr = 1'b0; e.ir = 1'b0;
      if (int'($urandom_range(0, 99)) < push_pct) begin
        case ($urandom_range(0, 2))
          0:       e.wr = 1'b1;
          1:       e.ir = 1'b1;
          default: begin e.wr = 1'b1; e.ir = 1'b1; end
        endcase
      end
      push_c1(e);
      deq0 = (int'($urandom_range(0, 99)) < deq_pct);
      deq1 = (int'($urandom_range(0, 99)) < deq_pct);
      buf_if.c0Rx = {1'($urandom()), 16'($urandom()), $urandom(), $urandom()};
      buf_if.c1Rx = {1'($urandom()), 16'($urandom())};
      buf_if.c0TxAlmFull = 1'($urandom());
      buf_if.c1TxAlmFull = 1'($urandom());
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end

    rst_n = 1'b1;
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
